// File: rtl/pcw_boot_pkg.sv
// Shared types and defaults for the PCW boot ROM download sequencer.
package pcw_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WRITE,
    ADVANCE,
    EXEC,
    DONE
  } boot_state_t;

  localparam logic [15:0] BOOT_ROM_END_DEFAULT = 16'd275;

  // Terminal value of a 3-bit cycle counter that must span 'cycles' clocks (1..7).
  function automatic logic [2:0] cnt_last(input int unsigned cycles);
    return 3'(cycles - 1);
  endfunction

endpackage

// File: rtl/pcw_boot_sequencer.sv
// Copies the boot ROM into core RAM through the download port after every
// core reset release, honours the core's wait handshake, then pulses the
// execute strobe. rom_data must be valid at the ROM_LATENCY-th rising edge
// after rom_addr was updated.
module pcw_boot_sequencer
  import pcw_boot_pkg::*;
#(
  parameter logic [15:0] BOOT_ROM_END = BOOT_ROM_END_DEFAULT,
  parameter int unsigned ROM_LATENCY  = 1,
  parameter int unsigned WR_CYCLES    = 1,
  parameter logic [15:0] LOAD_BASE    = 16'h0000,
  parameter logic [15:0] EXEC_ADDR    = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        core_reset,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        loader_wait,
  output logic        dn_go,
  output logic        dn_wr,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic [15:0] execute_addr,
  output logic        execute_enable,
  output logic        busy
);

  localparam logic [2:0] LAT_LAST = cnt_last(ROM_LATENCY);
  localparam logic [2:0] WR_LAST  = cnt_last(WR_CYCLES);

  boot_state_t state_q, state_d;
  logic        core_reset_q;
  logic [15:0] idx_q, idx_d;
  logic [15:0] rom_addr_q, rom_addr_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [2:0]  wr_cnt_q, wr_cnt_d;
  logic        dn_go_q, dn_go_d;
  logic        dn_wr_q, dn_wr_d;
  logic [15:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic        exec_en_q, exec_en_d;
  logic        busy_q, busy_d;
  logic        start;

  // Next-state and next-output logic; every output is registered, so each
  // state's output values are loaded on the edge that enters that state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    lat_cnt_d  = lat_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    dn_go_d    = dn_go_q;
    dn_wr_d    = dn_wr_q;
    dn_addr_d  = dn_addr_q;
    dn_data_d  = dn_data_q;
    exec_en_d  = 1'b0;
    start      = core_reset_q & ~core_reset;

    if (core_reset) begin
      // Abort immediately; a half-finished write is simply dropped.
      state_d = IDLE;
      dn_go_d = 1'b0;
      dn_wr_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d    = FETCH;
            idx_d      = '0;
            rom_addr_d = '0;
            lat_cnt_d  = '0;
            dn_go_d    = 1'b1;
          end
        end
        FETCH: begin
          if (lat_cnt_q == LAT_LAST) begin
            // Capture here so address/data settle one cycle before dn_wr rises.
            state_d   = LATCH;
            dn_data_d = rom_data;
            dn_addr_d = LOAD_BASE + idx_q;
          end else begin
            lat_cnt_d = lat_cnt_q + 3'd1;
          end
        end
        LATCH: begin
          state_d  = WRITE;
          dn_wr_d  = 1'b1;
          wr_cnt_d = '0;
        end
        WRITE: begin
          if ((wr_cnt_q == WR_LAST) && !loader_wait) begin
            state_d = ADVANCE;
            dn_wr_d = 1'b0;
          end else if (wr_cnt_q != WR_LAST) begin
            wr_cnt_d = wr_cnt_q + 3'd1;
          end
        end
        ADVANCE: begin
          // Equality compare so an end address of 16'hFFFF never wraps idx.
          if (idx_q == BOOT_ROM_END) begin
            state_d   = EXEC;
            exec_en_d = 1'b1;
            dn_go_d   = 1'b0;
          end else begin
            state_d    = FETCH;
            idx_d      = idx_q + 16'd1;
            rom_addr_d = idx_q + 16'd1;
            lat_cnt_d  = '0;
          end
        end
        EXEC: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // State, counters, edge detect and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      core_reset_q <= 1'b1;
      idx_q        <= '0;
      rom_addr_q   <= '0;
      lat_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      dn_go_q      <= 1'b0;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      exec_en_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= core_reset;
      idx_q        <= idx_d;
      rom_addr_q   <= rom_addr_d;
      lat_cnt_q    <= lat_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      dn_go_q      <= dn_go_d;
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      exec_en_q    <= exec_en_d;
      busy_q       <= busy_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign dn_go          = dn_go_q;
  assign dn_wr          = dn_wr_q;
  assign dn_addr        = dn_addr_q;
  assign dn_data        = dn_data_q;
  assign execute_addr   = EXEC_ADDR;
  assign execute_enable = exec_en_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_pcw_boot_sequencer.sv
// Self-checking bench for pcw_boot_sequencer: scoreboard of expected writes
// compared against every dn_wr pulse, plus a table of download scenarios.
module tb_pcw_boot_sequencer;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Default-parameter instance
  logic        reset_n, core_reset, loader_wait;
  logic [15:0] rom_addr, dn_addr, execute_addr;
  logic [7:0]  rom_data, dn_data;
  logic        dn_go, dn_wr, execute_enable, busy;

  // Parameter-sweep instance
  logic        reset_n2, core_reset2, loader_wait2;
  logic [15:0] rom_addr2, dn_addr2, execute_addr2;
  logic [7:0]  rom_data2, dn_data2;
  logic        dn_go2, dn_wr2, execute_enable2, busy2;

  pcw_boot_sequencer dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .core_reset(core_reset),
    .rom_addr(rom_addr), .rom_data(rom_data), .loader_wait(loader_wait),
    .dn_go(dn_go), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .execute_addr(execute_addr), .execute_enable(execute_enable), .busy(busy)
  );

  pcw_boot_sequencer #(
    .BOOT_ROM_END(16'd31), .ROM_LATENCY(3), .WR_CYCLES(2),
    .LOAD_BASE(16'hFFF0), .EXEC_ADDR(16'h1234)
  ) dut2 (
    .clk_sys(clk_sys), .reset_n(reset_n2), .core_reset(core_reset2),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .loader_wait(loader_wait2),
    .dn_go(dn_go2), .dn_wr(dn_wr2), .dn_addr(dn_addr2), .dn_data(dn_data2),
    .execute_addr(execute_addr2), .execute_enable(execute_enable2), .busy(busy2)
  );

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // ROM models: latency 1 = valid by the next edge, latency 3 = two extra stages
  assign rom_data = rom_f(rom_addr);
  logic [15:0] r2_s1, r2_s2;
  always @(posedge clk_sys) begin
    r2_s1 <= rom_addr2;
    r2_s2 <= r2_s1;
  end
  assign rom_data2 = rom_f(r2_s2);

  // Observed-DUT mux
  logic sel = 1'b0;
  wire        m_wr   = sel ? dn_wr2 : dn_wr;
  wire        m_go   = sel ? dn_go2 : dn_go;
  wire        m_exe  = sel ? execute_enable2 : execute_enable;
  wire        m_busy = sel ? busy2 : busy;
  wire        m_rstn = sel ? reset_n2 : reset_n;
  wire [15:0] m_addr = sel ? dn_addr2 : dn_addr;
  wire [7:0]  m_data = sel ? dn_data2 : dn_data;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          rise;
    int          width;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    int wait_byte;
    int wait_len;
    int exp_exec;
  } scen_t;
  scen_t scen [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on each dn_wr rise, checks width/stability
  int          cyc = 0, t0 = 0, wr_cnt = 0, exe_cnt = 0, exe_t = -1, width = 0;
  logic        p_wr = 1'b0, p_go = 1'b0, stable = 1'b0, post_chk = 1'b0;
  logic [15:0] p_addr = '0, cap_addr = '0;
  logic [7:0]  p_data = '0, cap_data = '0;
  wr_t         cur;
  always @(negedge clk_sys) begin
    cyc++;
    if (post_chk) begin
      post_chk = 1'b0;
      if (m_rstn) check("hold_after_wr", {8'h0, m_addr, m_data}, {8'h0, cap_addr, cap_data});
    end
    if (m_go && !p_go) t0 = cyc;
    if (m_wr && !p_wr) begin
      wr_cnt++;
      width    = 1;
      cap_addr = m_addr;
      cap_data = m_data;
      stable   = (m_addr == p_addr) && (m_data == p_data);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        cur.width = 0;
        $display("FAIL extra_write: dn_addr 0x%0h with no write expected", m_addr);
      end else begin
        cur = exp_q.pop_front();
        check("wr_addr", 32'(m_addr), 32'(cur.addr));
        check("wr_data", 32'(m_data), 32'(cur.data));
        check("wr_rise_cycle", cyc - t0, cur.rise);
      end
    end else if (m_wr) begin
      width++;
      if ((m_addr != cap_addr) || (m_data != cap_data)) stable = 1'b0;
    end else if (p_wr) begin
      check("wr_width", width, cur.width);
      check("wr_stable", 32'(stable), 32'd1);
      post_chk = 1'b1;
    end
    if (m_exe) begin
      exe_cnt++;
      exe_t = cyc - t0;
      check("go_low_at_exec", 32'(m_go), 32'd0);
    end
    p_wr   = m_wr;
    p_go   = m_go;
    p_addr = m_addr;
    p_data = m_data;
  end

  task automatic push_run(input int n, input int lat, input int wrc,
                          input logic [15:0] base, input int wb, input int wl);
    int  t;
    wr_t r;
    t = 0;
    for (int i = 0; i < n; i++) begin
      r.addr  = base + 16'(i);
      r.data  = rom_f(16'(i));
      r.rise  = t + lat + 1;
      r.width = wrc + ((i == wb) ? wl : 0);
      exp_q.push_back(r);
      t += lat + wrc + 2 + ((i == wb) ? wl : 0);
    end
  endtask

  task automatic run_to_exec(input int wb, input int wl, output bit ok);
    int e0, wc;
    bit armed;
    e0    = exe_cnt;
    wc    = 0;
    armed = (wl > 0);
    ok    = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_sys); #1;
      if (armed && dn_wr && (dn_addr == 16'(wb))) begin
        loader_wait = 1'b1;
        wc          = wl;
        armed       = 1'b0;
      end else if (wc > 0) begin
        wc--;
        if (wc == 0) loader_wait = 1'b0;
      end
      if (exe_cnt != e0) begin
        ok = 1'b1;
        break;
      end
    end
    loader_wait = 1'b0;
    repeat (3) @(negedge clk_sys);
    #1;
  endtask

  task automatic finish_run(input bit ok, input int n, input int exp_exec,
                            input int e0, input int w0);
    check("exec_seen", 32'(ok), 32'd1);
    check("exec_cycle", exe_t, exp_exec);
    check("exec_pulses", exe_cnt - e0, 1);
    check("write_total", wr_cnt - w0, n);
    check("writes_pending", exp_q.size(), 0);
    check("busy_in_done", 32'(m_busy), 32'd0);
    check("go_in_done", 32'(m_go), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit ok, found;
    int e0, w0;

    scen[0] = '{wait_byte: -1,  wait_len: 0, exp_exec: 1104};
    scen[1] = '{wait_byte: 10,  wait_len: 5, exp_exec: 1109};
    scen[2] = '{wait_byte: 275, wait_len: 2, exp_exec: 1106};

    reset_n  = 1'b0; core_reset  = 1'b0; loader_wait  = 1'b0;
    reset_n2 = 1'b0; core_reset2 = 1'b0; loader_wait2 = 1'b0;
    repeat (3) @(negedge clk_sys);
    #1;
    check("rst_dn_go", 32'(dn_go), 32'd0);
    check("rst_dn_wr", 32'(dn_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_exec_en", 32'(execute_enable), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_dn_addr_data", {8'h0, dn_addr, dn_data}, 32'd0);
    check("rst_exec_addr", 32'(execute_addr), 32'h0000);
    check("rst_exec_addr2", 32'(execute_addr2), 32'h1234);

    // Power-up boot: releasing reset_n with core_reset low starts a download
    push_run(276, 1, 1, 16'h0000, -1, 0);
    e0 = exe_cnt; w0 = wr_cnt;
    reset_n = 1'b1;
    run_to_exec(-1, 0, ok);
    finish_run(ok, 276, 1104, e0, w0);
    check("exec_addr_default", 32'(execute_addr), 32'h0000);

    // Re-triggered downloads from DONE, with and without wait stretching
    for (int s = 0; s < 3; s++) begin
      core_reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      push_run(276, 1, 1, 16'h0000, scen[s].wait_byte, scen[s].wait_len);
      e0 = exe_cnt; w0 = wr_cnt;
      core_reset = 1'b0;
      run_to_exec(scen[s].wait_byte, scen[s].wait_len, ok);
      finish_run(ok, 276, scen[s].exp_exec, e0, w0);
    end

    // Abort with core_reset during byte 100, then a full restart
    core_reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    push_run(101, 1, 1, 16'h0000, -1, 0);
    e0 = exe_cnt; w0 = wr_cnt;
    core_reset = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_sys); #1;
      if (dn_wr && (dn_addr == 16'd100)) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_byte100", 32'(found), 32'd1);
    core_reset = 1'b1;
    @(negedge clk_sys); #1;
    check("abort_dn_go", 32'(dn_go), 32'd0);
    check("abort_dn_wr", 32'(dn_wr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk_sys);
    #1;
    check("abort_no_exec", exe_cnt - e0, 0);
    check("abort_write_total", wr_cnt - w0, 101);
    check("abort_pending", exp_q.size(), 0);
    exp_q.delete();
    push_run(276, 1, 1, 16'h0000, -1, 0);
    e0 = exe_cnt; w0 = wr_cnt;
    core_reset = 1'b0;
    run_to_exec(-1, 0, ok);
    finish_run(ok, 276, 1104, e0, w0);

    // Asynchronous reset between clock edges in the middle of a write
    core_reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    push_run(6, 1, 1, 16'h0000, -1, 0);
    e0 = exe_cnt; w0 = wr_cnt;
    core_reset = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_sys); #1;
      if (dn_wr && (dn_addr == 16'd5)) begin
        found = 1'b1;
        break;
      end
    end
    check("async_reached_byte5", 32'(found), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async_dn_wr", 32'(dn_wr), 32'd0);
    check("async_dn_go", 32'(dn_go), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_exec_en", 32'(execute_enable), 32'd0);
    repeat (3) @(negedge clk_sys);
    #1;
    check("async_write_total", wr_cnt - w0, 6);
    check("async_no_exec", exe_cnt - e0, 0);
    exp_q.delete();
    push_run(276, 1, 1, 16'h0000, -1, 0);
    e0 = exe_cnt; w0 = wr_cnt;
    reset_n = 1'b1;
    run_to_exec(-1, 0, ok);
    finish_run(ok, 276, 1104, e0, w0);

    // Parameter sweep: latency 3, write width 2, base 0xFFF0 (address wraps at byte 16)
    sel = 1'b1;
    @(negedge clk_sys); #1;
    push_run(32, 3, 2, 16'hFFF0, -1, 0);
    e0 = exe_cnt; w0 = wr_cnt;
    reset_n2 = 1'b1;
    run_to_exec(-1, 0, ok);
    finish_run(ok, 32, 224, e0, w0);
    check("sweep_exec_addr", 32'(execute_addr2), 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
